sha_block: RTL and testbench

- Iterative SHA-256 compression engine for the bitcoin miner datapath.
- Computes one 64-round SHA-256 compression of a 512-bit message block, chained onto a supplied 256-bit previous hash state.
- Returns the updated hash state plus a pass-through nonce tag, then pulses a done strobe.
- Sits between the work/nonce generator and the hash comparator; instances can be cascaded via en_next.

---
 rtl/sha256_pkg.sv | 68 ++++++
 rtl/sha_round.sv | 40 ++++
 rtl/sha_block.sv | 136 +++++++++++++
 tb/tb_sha_block.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and FIPS 180-4 helper functions for the SHA-256 engine.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int ROUNDS = 64;

  // Round constants packed like the K port: K[t] lives in bits [32t+31:32t].
  localparam logic [2047:0] SHA256_K = {
    32'hc67178f2, 32'hbef9a3f7, 32'ha4506ceb, 32'h90befffa,
    32'h8cc70208, 32'h84c87814, 32'h78a5636f, 32'h748f82ee,
    32'h682e6ff3, 32'h5b9cca4f, 32'h4ed8aa4a, 32'h391c0cb3,
    32'h34b0bcb5, 32'h2748774c, 32'h1e376c08, 32'h19a4c116,
    32'h106aa070, 32'hf40e3585, 32'hd6990624, 32'hd192e819,
    32'hc76c51a3, 32'hc24b8b70, 32'ha81a664b, 32'ha2bfe8a1,
    32'h92722c85, 32'h81c2c92e, 32'h766a0abb, 32'h650a7354,
    32'h53380d13, 32'h4d2c6dfc, 32'h2e1b2138, 32'h27b70a85,
    32'h14292967, 32'h06ca6351, 32'hd5a79147, 32'hc6e00bf3,
    32'hbf597fc7, 32'hb00327c8, 32'ha831c66d, 32'h983e5152,
    32'h76f988da, 32'h5cb0a9dc, 32'h4a7484aa, 32'h2de92c6f,
    32'h240ca1cc, 32'h0fc19dc6, 32'hefbe4786, 32'he49b69c1,
    32'hc19bf174, 32'h9bdc06a7, 32'h80deb1fe, 32'h72be5d74,
    32'h550c7dc3, 32'h243185be, 32'h12835b01, 32'hd807aa98,
    32'hab1c5ed5, 32'h923f82a4, 32'h59f111f1, 32'h3956c25b,
    32'he9b5dba5, 32'hb5c0fbcf, 32'h71374491, 32'h428a2f98
  };

  // Initial hash value, word 0 (a) in the MSBs like H_prev.
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_round.sv
// One combinational SHA-256 compression round over the working variables a..h.
module sha_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next,
  output logic [31:0] f_next,
  output logic [31:0] g_next,
  output logic [31:0] h_next
);

  word_t t1;
  word_t t2;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;

endmodule

// File: rtl/sha_block.sv
// Iterative SHA-256 compression engine: one round per clock, then a final
// chaining addition and a one-cycle done strobe on en_next.
module sha_block
  import sha256_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [31:0]    nonce,
  input  logic [2047:0]  K,
  input  logic [511:0]   M,
  input  logic [255:0]   H_prev,
  output logic [255:0]   H,
  output logic [31:0]    nonce_out,
  output logic           en_next
);

  state_t         state;
  state_t         state_next;
  logic           load;
  logic [6:0]     t;
  logic [511:0]   w_win;
  logic [2047:0]  k_reg;
  logic [255:0]   hp_reg;
  logic [255:0]   v_reg;
  logic [255:0]   v_next;
  logic [255:0]   h_sum;
  logic [31:0]    nonce_reg;
  word_t          w_new;

  // The W window holds W[t] in its top word; the next schedule word W[t+16]
  // is built from W[t+14], W[t+9], W[t+1] and W[t] and shifted in at the bottom.
  assign w_new = small_sigma1(w_win[63:32]) + w_win[223:192]
               + small_sigma0(w_win[479:448]) + w_win[511:480];

  sha_round u_round (
    .a      (v_reg[255:224]),
    .b      (v_reg[223:192]),
    .c      (v_reg[191:160]),
    .d      (v_reg[159:128]),
    .e      (v_reg[127:96]),
    .f      (v_reg[95:64]),
    .g      (v_reg[63:32]),
    .h      (v_reg[31:0]),
    .k      (k_reg[31:0]),
    .w      (w_win[511:480]),
    .a_next (v_next[255:224]),
    .b_next (v_next[223:192]),
    .c_next (v_next[191:160]),
    .d_next (v_next[159:128]),
    .e_next (v_next[127:96]),
    .f_next (v_next[95:64]),
    .g_next (v_next[63:32]),
    .h_next (v_next[31:0])
  );

  // Chain the working variables onto the previous hash, word by word.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[255-32*i -: 32] = hp_reg[255-32*i -: 32] + v_reg[255-32*i -: 32];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DONE accepts a new job exactly like IDLE; the extra
  // RUN cycle at t == 64 performs the final addition.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    en_next    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (t == 7'(ROUNDS)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        en_next = 1'b1;
        if (en) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the job on acceptance, iterate rounds, then publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t         <= '0;
      w_win     <= '0;
      k_reg     <= '0;
      hp_reg    <= '0;
      v_reg     <= '0;
      nonce_reg <= '0;
      H         <= '0;
      nonce_out <= '0;
    end else if (load) begin
      t         <= '0;
      w_win     <= M;
      k_reg     <= K;
      hp_reg    <= H_prev;
      v_reg     <= H_prev;
      nonce_reg <= nonce;
    end else if (state == RUN) begin
      if (t < 7'(ROUNDS)) begin
        v_reg <= v_next;
        w_win <= {w_win[479:0], w_new};
        k_reg <= {32'h0, k_reg[2047:32]};
        t     <= t + 7'd1;
      end else begin
        H         <= h_sum;
        nonce_out <= nonce_reg;
      end
    end
  end

endmodule

// File: tb/tb_sha_block.sv
// Scoreboard bench for sha_block using known SHA-256 compression vectors.
module tb_sha_block;

  typedef struct {
    logic [255:0] h;
    logic [31:0]  nonce;
    int           cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           en_i = 1'b0;
  logic [31:0]    nonce_i = '0;
  logic [2047:0]  k_i = '0;
  logic [511:0]   m_i = '0;
  logic [255:0]   hprev_i = '0;
  logic [255:0]   h_o;
  logic [31:0]    nonce_o;
  logic           en_next_o;

  exp_t sb[$];
  int   vectors = 0;
  int   misc = 0;
  int   cyc = 0;
  bit   prev_done = 1'b0;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] M1 =
    512'h02000000671D0E2FF45DD1E927A51219D1CA1065C93B0C4E8840290A00000000000000002CD900FC3513260DF5BD2EABFD456CD2B3D2BACE30CC078215A907C0;
  localparam logic [255:0] H1 =
    256'h09A0D19192EF77C304FE447888F9EF5069D648465A19146FB770619714D08904;
  localparam logic [511:0] M2 = {32'h45F4992E, 32'h74749054, 32'h747B1B18, 32'h43F740C0,
                                 32'h80000000, 320'h0, 32'h00000280};
  localparam logic [255:0] H2 =
    256'hF4A4F82759D9117B8714F483DB052DA41B1D147424E315F86BB97C82B87254E3;
  localparam logic [511:0] M3 = {32'h80000000, 480'h0};
  localparam logic [255:0] H3 =
    256'hE3B0C44298FC1C149AFBF4C8996FB92427AE41E4649B934CA495991B7852B855;

  sha_block dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en_i),
    .nonce     (nonce_i),
    .K         (k_i),
    .M         (m_i),
    .H_prev    (hprev_i),
    .H         (h_o),
    .nonce_out (nonce_o),
    .en_next   (en_next_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard on every done strobe and checks that
  // the strobe lasts a single cycle.
  always @(negedge clk) begin
    if (prev_done) begin
      vectors++;
      if (en_next_o !== 1'b0) begin
        $display("[TB] FAIL strobe_width: en_next=%b required 0 at cycle %0d", en_next_o, cyc);
        misc++;
      end
    end
    if (en_next_o === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        misc++;
        $display("[TB] FAIL spurious_done: en_next=1 with no job pending at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (h_o !== e.h) begin
          $display("[TB] FAIL hash: got %h required %h", h_o, e.h);
          misc++;
        end
        vectors++;
        if (nonce_o !== e.nonce) begin
          $display("[TB] FAIL nonce_out: got %h required %h", nonce_o, e.nonce);
          misc++;
        end
        vectors++;
        if (cyc !== e.cyc) begin
          $display("[TB] FAIL latency: done at cycle %0d required %0d", cyc, e.cyc);
          misc++;
        end
      end
    end
    prev_done = (en_next_o === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic start_job(input logic [511:0] m, input logic [255:0] hp, input logic [31:0] n,
                           input logic [255:0] exp_h, input bit push, output int acc);
    @(negedge clk);
    m_i = m;
    hprev_i = hp;
    nonce_i = n;
    en_i = 1'b1;
    acc = cyc + 1;
    if (push) sb.push_back('{h: exp_h, nonce: n, cyc: acc + 65});
    @(negedge clk);
    en_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    vectors++;
    if (sb.size() != 0) begin
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      misc++;
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (h_o !== 256'h0) begin
      $display("[TB] FAIL reset_H: got %h required 0", h_o);
      misc++;
    end
    vectors++;
    if (nonce_o !== 32'h0) begin
      $display("[TB] FAIL reset_nonce: got %h required 0", nonce_o);
      misc++;
    end
    vectors++;
    if (en_next_o !== 1'b0) begin
      $display("[TB] FAIL reset_en_next: got %b required 0", en_next_o);
      misc++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (h_o !== 256'h0) begin
      $display("[TB] FAIL idle_H: got %h required 0", h_o);
      misc++;
    end
  endtask

  task automatic test_block1();
    int acc;
    start_job(M1, IV, 32'h11, H1, 1'b1, acc);
    wait_drain(100);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc;
    @(negedge clk);
    m_i = M2;
    hprev_i = IV;
    nonce_i = 32'h11;
    en_i = 1'b1;
    acc = cyc + 1;
    for (int j = 0; j < 3; j++) sb.push_back('{h: H2, nonce: 32'h11, cyc: acc + 65 + 66 * j});
    while (cyc < acc + 197) @(negedge clk);
    en_i = 1'b0;
    wait_drain(50);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int acc;
    start_job(M1, IV, 32'h11, H1, 1'b1, acc);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      en_i = 1'($urandom_range(0, 1));
      m_i = {16{$urandom()}};
      hprev_i = {8{$urandom()}};
      nonce_i = $urandom();
    end
    en_i = 1'b0;
    wait_drain(100);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int acc;
    start_job(M2, IV, 32'h22, H2, 1'b0, acc);
    while (cyc < acc + 31) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (h_o !== 256'h0) begin
      $display("[TB] FAIL abort_H: got %h required 0", h_o);
      misc++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    vectors++;
    if (nonce_o !== 32'h0) begin
      $display("[TB] FAIL abort_nonce: got %h required 0", nonce_o);
      misc++;
    end
    test_block1();
  endtask

  task automatic test_empty_message();
    int acc;
    start_job(M3, IV, 32'hCAFE0001, H3, 1'b1, acc);
    wait_drain(100);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) k_i[32*i +: 32] = k_tab[i];
    $display("[TB] starting sha_block bench");
    test_reset();
    test_block1();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_run();
    test_empty_message();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
